// File: rtl/aes_block_sequencer.sv
// Purpose: loads a 128-bit block word-by-word into the AES decoder, kicks the core, streams the result out.
// Latency: 4 load + 1 settle + 1 start + core latency + 4 unload cycles, minimum turnaround.
// Backpressure: in_ready only in LOAD (producer holds words); out_data held while out_valid && !out_ready.
module aes_block_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic [31:0]        dec_din,
    output logic [1:0]         dec_sel,
    output logic               core_start,
    input  logic               core_done,
    input  logic [127:0]       core_result,
    output logic               out_valid,
    output logic [31:0]        out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   block_count
);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_SETTLE = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [1:0]        ocnt_q, ocnt_d;
    logic [31:0]       din_q, din_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0][31:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;

    // The decoder rewrites dout[sel] every edge, so din/sel come straight from
    // registers that only move on an accepted input word.
    assign dec_din     = din_q;
    assign dec_sel     = sel_q;
    assign out_data    = hold_q[ocnt_q];
    assign block_count = bcnt_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            wcnt_q  <= 2'd0;
            ocnt_q  <= 2'd0;
            din_q   <= 32'd0;
            sel_q   <= 2'd0;
            hold_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ocnt_q  <= ocnt_d;
            din_q   <= din_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state and handshake outputs; everything defaults to hold.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        ocnt_d     = ocnt_q;
        din_d      = din_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        bcnt_d     = bcnt_q;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;

        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = (wcnt_q != 2'd0);
                if (in_valid) begin
                    din_d  = in_data;
                    sel_d  = wcnt_q;
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) begin
                        wcnt_d  = 2'd0;
                        state_d = S_SETTLE;
                    end
                end
            end
            // Extra cycle so the decoder captures word 3 before the core starts.
            S_SETTLE: state_d = S_START;
            S_START: begin
                core_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    hold_d  = core_result;
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ocnt_d = ocnt_q + 2'd1;
                    if (ocnt_q == 2'd3) begin
                        ocnt_d  = 2'd0;
                        bcnt_d  = bcnt_q + CNT_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

endmodule

// File: doc/aes_block_sequencer.md
# aes_block_sequencer

Controller that sequences the AES 32-bit word decoder and the AES round core. It accepts a 128-bit block as four 32-bit words over a valid/ready stream and steers each word into the decoder's four word registers. It then starts the core, waits for completion, and streams the 128-bit result back out as four words. It sits between the host word bus and the decoder/core pair, and is the only driver of the decoder's `din`/`sel` inputs.

## Interface
Parameters:
- `CNT_W`, default 16: width of the completed-block counter.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `in_valid`, input, 1: input word valid.
- `in_data`, input, 32: input word; word 0 first.
- `in_ready`, output, 1: sequencer can accept an input word.
- `dec_din`, output, 32: drives decoder `din`.
- `dec_sel`, output, 2: drives decoder `sel`.
- `core_start`, output, 1: one-cycle start pulse to the AES core.
- `core_done`, input, 1: core result valid (pulse or level; sampled only in WAIT).
- `core_result`, input, 128: core output block.
- `out_valid`, output, 1: output word valid.
- `out_data`, output, 32: output word; word 0 first.
- `out_ready`, input, 1: downstream accepts the output word.
- `busy`, output, 1: high in any state except LOAD with word count 0.
- `block_count`, output, CNT_W: number of completed blocks, wrapping.

## Operation
- The decoder writes `dout[sel] <= din` on every edge and has no enable. The sequencer therefore drives `dec_din` and `dec_sel` from registers `din_q` and `sel_q`, which change only on an accepted input word. Holding them stable rewrites the same value, so decoder contents are preserved.
- Word mapping:
  - Input word i lands in decoder `dout<i>`.
  - Output word i is `core_result[32i+31:32i]`.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `din_q <= in_data`, `sel_q <= wcnt`, `wcnt <= wcnt+1`.
  - When the accepted word is word 3, go to SETTLE and set `wcnt` to 0.
- SETTLE: one cycle; `in_ready` = 0. This gives the decoder its capture edge for word 3. Next state is START.
- START: `core_start` = 1 for exactly one cycle. Next state is WAIT.
- WAIT:
  - Stay until `core_done` = 1.
  - Then capture `core_result` into a 128-bit holding register and go to UNLOAD.
  - `core_done` seen outside WAIT is ignored.
- UNLOAD:
  - `out_valid` = 1 and `out_data` = holding word `ocnt`.
  - On `out_valid && out_ready`: `ocnt <= ocnt+1`.
  - After word 3 is accepted: `ocnt` = 0, `block_count <= block_count+1` (modulo 2^CNT_W), and go to LOAD.
- Outside LOAD, `in_ready` = 0. Input words are never dropped; the producer must hold them.
- `out_data` is held stable while `out_valid && !out_ready`.

## Timing
- Reset values (the edge with `rst`=1):
  - State LOAD; `wcnt`, `ocnt` = 0.
  - `din_q` = 0, `sel_q` = 0.
  - `core_start` = 0, `out_valid` = 0, `in_ready` = 1, `busy` = 0.
  - `block_count` = 0; holding register = 0.
- Reset mid-operation:
  - A partial block or an unfinished unload is discarded. The next accepted word is word 0.
  - The decoder's contents are not cleared, apart from `dout0` being written with 0 on the following edge.
- One input word per cycle maximum; a back-to-back burst loads four words in 4 cycles.
- If word 3 is accepted on edge E:
  - `dout3` is valid after E+1.
  - `core_start` is high in the cycle between E+1 and E+2.
  - WAIT begins at E+2.
- If `core_done` is sampled high on edge D, `out_valid` = 1 from D onward (registered, zero added wait).
- With `out_ready` held at 1, the four output words take 4 cycles. `in_ready` = 1 in the cycle after the edge that accepts the final output word.
- Minimum turnaround is 4 (load) + 1 (SETTLE) + 1 (START) + core latency + 4 (unload) cycles.
- `block_count` wraps from 2^CNT_W−1 to 0 without a flag.

## Test plan
- Reset, then a back-to-back burst 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with `in_valid`=1 -> decoder `dout0..3` hold those words in order. `core_start` is a single pulse 2 cycles after the 4th accept, and `in_ready` = 0 from SETTLE until UNLOAD ends.
- Gapped input (`in_valid` toggling 1,0,0,1,...) -> `dec_din`/`dec_sel` hold stable in gap cycles, and decoder words are unchanged between accepts.
- `core_done` pulsed in START, then again 10 cycles into WAIT with `core_result` = 0x0123456789ABCDEF_FEDCBA9876543210 -> the first pulse is ignored. Outputs are 0x76543210, 0xFEDCBA98, 0x89ABCDEF, 0x01234567.
- Output backpressure: `out_ready` low for 3 cycles on word 1 -> `out_data` stays 0xFEDCBA98 with `out_valid`=1. No word is skipped or duplicated.
- Assert `rst` after 2 input words, then send a fresh 4-word block -> the block loads from `dout0`, `block_count` = 0, and no `core_start` occurs before the 4th new word.
- With `CNT_W`=2, run 5 blocks -> `block_count` reads 1,2,3,0,1.
